// File: rtl/ipg_tx_arbiter.sv
// ---------------------------------------------------------------------------
// ipg_tx_arbiter
//
// Shares the IPG transmit slot between two message sources and forwards
// 64-bit control-block chunks into PHY idle slots:
//   - reply source   (rep_*): memory replies from the IPG processor memq
//   - request source (req_*): outgoing c_read / c_write messages
//
// Grants are message-atomic. When both sources are waiting, replies win
// until REPLY_WEIGHT reply messages in a row have been served; the next
// arbitration then goes to the request source. A granted source that
// stalls mid-message for TIMEOUT idle slots loses the grant. When that
// happens, err_timeout pulses for one cycle.
//
// Optional feature (macro IPG_BT_CHECK_EN):
//   A granted chunk whose block type (bits [7:0]) is not 8'h1e is still
//   consumed, but it is not forwarded. The extra output err_bt pulses for
//   one cycle. Without the macro there is no err_bt port, and every chunk
//   is forwarded unmodified.
//
// Ports:
//   clk            single clock
//   reset          synchronous active-low reset
//   rep_data/valid/last, rep_ready   reply chunk stream (ready is combinational)
//   req_data/valid/last, req_ready   request chunk stream (ready is combinational)
//   tx_slot_avail  PHY can carry a control block this cycle
//   tx_ipg_data    registered chunk to the PHY
//   tx_ipg_valid   tx_ipg_data valid (exactly one cycle after a handshake)
//   grant_src      one-hot grant: bit0 = reply, bit1 = request
//   err_timeout    one-cycle pulse when a stalled message is aborted
//   err_bt         (IPG_BT_CHECK_EN only) one-cycle pulse on a dropped chunk
//
// Parameters:
//   REPLY_WEIGHT   consecutive replies served while a request is pending
//   TIMEOUT        idle-slot cycles tolerated mid-message (>= 2)
//   STREAK_W       reply streak counter width, REPLY_WEIGHT < 2**STREAK_W
// ---------------------------------------------------------------------------
module ipg_tx_arbiter #(
  parameter int unsigned REPLY_WEIGHT = 32'd3,
  parameter int unsigned TIMEOUT      = 32'd16,
  parameter int unsigned STREAK_W     = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] rep_data,
  input  logic        rep_valid,
  input  logic        rep_last,
  output logic        rep_ready,
  input  logic [63:0] req_data,
  input  logic        req_valid,
  input  logic        req_last,
  output logic        req_ready,
  input  logic        tx_slot_avail,
  output logic [63:0] tx_ipg_data,
  output logic        tx_ipg_valid,
  output logic [1:0]  grant_src,
  output logic        err_timeout
`ifdef IPG_BT_CHECK_EN
  ,
  output logic        err_bt
`endif
);

  // Gap counter only has to reach TIMEOUT-1.
  localparam int unsigned GAP_W = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 32'd1;

  localparam logic [STREAK_W-1:0] WEIGHT_C     = STREAK_W'(REPLY_WEIGHT);
  localparam logic [STREAK_W-1:0] STREAK_ONE_C = STREAK_W'(32'd1);
  localparam logic [GAP_W-1:0]    GAP_LAST_C   = GAP_W'(TIMEOUT - 32'd1);
  localparam logic [GAP_W-1:0]    GAP_ONE_C    = GAP_W'(32'd1);

  // The BUSY encodings equal the one-hot grant value of the same source.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_BUSY_REP = 2'b01,
    ST_BUSY_REQ = 2'b10
  } state_e;

  // Reply streak after one more completed reply message, saturating at the weight.
  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] cur);
    logic [STREAK_W-1:0] nxt;
    if (cur >= WEIGHT_C) begin
      nxt = WEIGHT_C;
    end else begin
      nxt = cur + STREAK_ONE_C;
    end
    return nxt;
  endfunction

  // One-hot grant vector for a given arbiter state.
  function automatic logic [1:0] grant_of(input state_e st);
    logic [1:0] g;
    case (st)
      ST_BUSY_REP: g = 2'b01;
      ST_BUSY_REQ: g = 2'b10;
      default:     g = 2'b00;
    endcase
    return g;
  endfunction

`ifdef IPG_BT_CHECK_EN
  localparam logic [7:0] BT_CTRL_C = 8'h1e;

  // A chunk is forwardable only if it carries the control block type.
  function automatic logic bt_ok(input logic [63:0] chunk);
    return (chunk[7:0] == BT_CTRL_C);
  endfunction
`endif

  // Registered state and outputs
  state_e               state_q,    state_d;
  logic [STREAK_W-1:0]  streak_q,   streak_d;
  logic [GAP_W-1:0]     gap_q,      gap_d;
  logic [63:0]          tx_data_q,  tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [1:0]           grant_q,    grant_d;
  logic                 err_to_q,   err_to_d;
`ifdef IPG_BT_CHECK_EN
  logic                 err_bt_q,   err_bt_d;
`endif

  // Granted-source view (combinational)
  logic                 sel_valid_s;
  logic                 sel_last_s;
  logic [63:0]          sel_data_s;
  logic                 rep_ready_s;
  logic                 req_ready_s;
  logic                 hs_s;

  // Route the granted source to a common view and drive the ready strobes.
  // The non-granted source's ready is held at 0, and its data is never
  // selected.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = 64'd0;
    rep_ready_s = 1'b0;
    req_ready_s = 1'b0;
    case (state_q)
      ST_BUSY_REP: begin
        sel_valid_s = rep_valid;
        sel_last_s  = rep_last;
        sel_data_s  = rep_data;
        rep_ready_s = tx_slot_avail;
      end
      ST_BUSY_REQ: begin
        sel_valid_s = req_valid;
        sel_last_s  = req_last;
        sel_data_s  = req_data;
        req_ready_s = tx_slot_avail;
      end
      default: begin
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_data_s  = 64'd0;
        rep_ready_s = 1'b0;
        req_ready_s = 1'b0;
      end
    endcase
    hs_s = sel_valid_s && (rep_ready_s || req_ready_s);
  end

  // Next-state logic: arbitration, chunk forwarding, streak and stall timeout.
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    gap_d      = gap_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    err_to_d   = 1'b0;
`ifdef IPG_BT_CHECK_EN
    err_bt_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // Arbitration bubble: no chunk moves in IDLE.
        gap_d = {GAP_W{1'b0}};
        if (rep_valid && req_valid) begin
          if (streak_q == WEIGHT_C) begin
            state_d = ST_BUSY_REQ;
          end else begin
            state_d = ST_BUSY_REP;
          end
        end else if (rep_valid) begin
          state_d = ST_BUSY_REP;
        end else if (req_valid) begin
          state_d = ST_BUSY_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY_REP, ST_BUSY_REQ: begin
        if (hs_s) begin
          gap_d = {GAP_W{1'b0}};
`ifdef IPG_BT_CHECK_EN
          if (bt_ok(sel_data_s)) begin
            tx_data_d  = sel_data_s;
            tx_valid_d = 1'b1;
          end else begin
            err_bt_d   = 1'b1;
          end
`else
          tx_data_d  = sel_data_s;
          tx_valid_d = 1'b1;
`endif
          if (sel_last_s) begin
            state_d = ST_IDLE;
            if (state_q == ST_BUSY_REP) begin
              streak_d = streak_inc(streak_q);
            end else begin
              streak_d = {STREAK_W{1'b0}};
            end
          end else begin
            state_d = state_q;
          end
        end else if (tx_slot_avail) begin
          // Slot offered but the source had nothing: this counts as a stall
          // cycle. Cycles without a slot neither count nor clear the counter.
          if (gap_q == GAP_LAST_C) begin
            state_d  = ST_IDLE;
            gap_d    = {GAP_W{1'b0}};
            err_to_d = 1'b1;
          end else begin
            gap_d = gap_q + GAP_ONE_C;
          end
        end else begin
          gap_d = gap_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gap_d   = {GAP_W{1'b0}};
      end
    endcase
    grant_d = grant_of(state_d);
  end

  // State and output registers with synchronous active-low reset. Reset
  // drops any message in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      streak_q   <= {STREAK_W{1'b0}};
      gap_q      <= {GAP_W{1'b0}};
      tx_data_q  <= 64'd0;
      tx_valid_q <= 1'b0;
      grant_q    <= 2'b00;
      err_to_q   <= 1'b0;
`ifdef IPG_BT_CHECK_EN
      err_bt_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      gap_q      <= gap_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      grant_q    <= grant_d;
      err_to_q   <= err_to_d;
`ifdef IPG_BT_CHECK_EN
      err_bt_q   <= err_bt_d;
`endif
    end
  end

  assign rep_ready    = rep_ready_s;
  assign req_ready    = req_ready_s;
  assign tx_ipg_data  = tx_data_q;
  assign tx_ipg_valid = tx_valid_q;
  assign grant_src    = grant_q;
  assign err_timeout  = err_to_q;
`ifdef IPG_BT_CHECK_EN
  assign err_bt       = err_bt_q;
`endif

endmodule

// File: tb/tb_ipg_tx_arbiter.sv
module tb_ipg_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] rep_data;
  logic        rep_valid;
  logic        rep_last;
  logic        rep_ready;
  logic [63:0] req_data;
  logic        req_valid;
  logic        req_last;
  logic        req_ready;
  logic        tx_slot_avail;
  logic [63:0] tx_ipg_data;
  logic        tx_ipg_valid;
  logic [1:0]  grant_src;
  logic        err_timeout;
`ifdef IPG_BT_CHECK_EN
  logic        err_bt;
`endif

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [1:0]  order_c [8] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};

  always #5 clk = ~clk;

  ipg_tx_arbiter #(.REPLY_WEIGHT(3), .TIMEOUT(16), .STREAK_W(4)) dut (
    .clk(clk), .reset(reset),
    .rep_data(rep_data), .rep_valid(rep_valid), .rep_last(rep_last), .rep_ready(rep_ready),
    .req_data(req_data), .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
    .tx_slot_avail(tx_slot_avail), .tx_ipg_data(tx_ipg_data), .tx_ipg_valid(tx_ipg_valid),
    .grant_src(grant_src), .err_timeout(err_timeout)
`ifdef IPG_BT_CHECK_EN
    , .err_bt(err_bt)
`endif
  );

  function automatic logic [63:0] mk(input int tag, input int idx);
    logic [15:0] t;
    logic [15:0] i;
    t = tag[15:0];
    i = idx[15:0];
    return {t, i, 24'hC0FFEE, 8'h1e};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rep_valid = 1'b0; rep_last = 1'b0; rep_data = 64'd0;
    req_valid = 1'b0; req_last = 1'b0; req_data = 64'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    tx_slot_avail = 1'b1;
    reset = 1'b0;
    tick(); tick();
    @(negedge clk);
    checks += 6;
    if (tx_ipg_valid !== 1'b0) begin errors++; $display("FAIL reset tx_valid: got %b want 0", tx_ipg_valid); end
    if (tx_ipg_data !== 64'd0) begin errors++; $display("FAIL reset tx_data: got %h want 0", tx_ipg_data); end
    if (grant_src !== 2'b00) begin errors++; $display("FAIL reset grant: got %b want 00", grant_src); end
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset err_timeout: got %b want 0", err_timeout); end
    if (rep_ready !== 1'b0) begin errors++; $display("FAIL reset rep_ready: got %b want 0", rep_ready); end
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset req_ready: got %b want 0", req_ready); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reply_only();
    logic hs_prev;
    logic [63:0] exp_d;
    rep_valid = 1'b1; rep_data = mk(1, 0); rep_last = 1'b0; tx_slot_avail = 1'b1;
    @(negedge clk);
    checks += 2;
    if (grant_src !== 2'b00) begin errors++; $display("FAIL reply_only bubble grant: got %b want 00", grant_src); end
    if (rep_ready !== 1'b0) begin errors++; $display("FAIL reply_only bubble rep_ready: got %b want 0", rep_ready); end
    tick();
    hs_prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rep_data = mk(1, i); rep_last = (i == 9);
      @(negedge clk);
      checks += 3;
      if (tx_ipg_valid !== hs_prev) begin errors++; $display("FAIL reply_only tx_valid[%0d]: got %b want %b", i, tx_ipg_valid, hs_prev); end
      if (hs_prev) begin
        exp_d = exp_q.pop_front(); checks++;
        if (tx_ipg_data !== exp_d) begin errors++; $display("FAIL reply_only tx_data: got %h want %h", tx_ipg_data, exp_d); end
      end
      if (grant_src !== 2'b01) begin errors++; $display("FAIL reply_only grant[%0d]: got %b want 01", i, grant_src); end
      if (rep_ready !== 1'b1) begin errors++; $display("FAIL reply_only rep_ready[%0d]: got %b want 1", i, rep_ready); end
      exp_q.push_back(mk(1, i)); hs_prev = 1'b1;
      tick();
    end
    rep_valid = 1'b0; rep_last = 1'b0;
    @(negedge clk);
    exp_d = exp_q.pop_front();
    checks += 3;
    if (tx_ipg_valid !== 1'b1) begin errors++; $display("FAIL reply_only last tx_valid: got %b want 1", tx_ipg_valid); end
    if (tx_ipg_data !== exp_d) begin errors++; $display("FAIL reply_only last tx_data: got %h want %h", tx_ipg_data, exp_d); end
    if (grant_src !== 2'b00) begin errors++; $display("FAIL reply_only idle grant: got %b want 00", grant_src); end
    tick();
    @(negedge clk);
    checks += 2;
    if (tx_ipg_valid !== 1'b0) begin errors++; $display("FAIL reply_only trailing tx_valid: got %b want 0", tx_ipg_valid); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL reply_only scoreboard: got %0d left want 0", exp_q.size()); end
    tick();
  endtask

  task automatic test_back_pressure();
    logic hs_prev;
    logic slot;
    logic [63:0] exp_d;
    int j;
    req_valid = 1'b1; req_data = mk(2, 0); req_last = 1'b0; tx_slot_avail = 1'b1;
    @(negedge clk);
    checks++;
    if (grant_src !== 2'b00) begin errors++; $display("FAIL back_pressure bubble grant: got %b want 00", grant_src); end
    tick();
    hs_prev = 1'b0; j = 0;
    for (int k = 0; k < 7; k++) begin
      slot = (k % 2 == 0);
      tx_slot_avail = slot; req_data = mk(2, j); req_last = (j == 3);
      @(negedge clk);
      checks += 5;
      if (tx_ipg_valid !== hs_prev) begin errors++; $display("FAIL back_pressure tx_valid[%0d]: got %b want %b", k, tx_ipg_valid, hs_prev); end
      if (hs_prev) begin
        exp_d = exp_q.pop_front(); checks++;
        if (tx_ipg_data !== exp_d) begin errors++; $display("FAIL back_pressure tx_data: got %h want %h", tx_ipg_data, exp_d); end
      end
      if (req_ready !== slot) begin errors++; $display("FAIL back_pressure req_ready[%0d]: got %b want %b", k, req_ready, slot); end
      if (rep_ready !== 1'b0) begin errors++; $display("FAIL back_pressure rep_ready[%0d]: got %b want 0", k, rep_ready); end
      if (grant_src !== 2'b10) begin errors++; $display("FAIL back_pressure grant[%0d]: got %b want 10", k, grant_src); end
      if (err_timeout !== 1'b0) begin errors++; $display("FAIL back_pressure err_timeout[%0d]: got %b want 0", k, err_timeout); end
      hs_prev = slot;
      if (slot) begin exp_q.push_back(mk(2, j)); end
      tick();
      if (slot) begin j++; end
    end
    req_valid = 1'b0; req_last = 1'b0; tx_slot_avail = 1'b1;
    @(negedge clk);
    exp_d = exp_q.pop_front();
    checks += 3;
    if (tx_ipg_valid !== 1'b1) begin errors++; $display("FAIL back_pressure last tx_valid: got %b want 1", tx_ipg_valid); end
    if (tx_ipg_data !== exp_d) begin errors++; $display("FAIL back_pressure last tx_data: got %h want %h", tx_ipg_data, exp_d); end
    if (grant_src !== 2'b00) begin errors++; $display("FAIL back_pressure idle grant: got %b want 00", grant_src); end
    tick();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL back_pressure scoreboard: got %0d left want 0", exp_q.size()); end
    tick();
  endtask

  task automatic test_weighting();
    logic hs_prev;
    logic [63:0] exp_d;
    logic [1:0] g;
    int rm, rc, qm, qc;
    idle_inputs();
    reset = 1'b0; tick(); reset = 1'b1;
    rm = 0; rc = 0; qm = 0; qc = 0; hs_prev = 1'b0;
    rep_valid = 1'b1; req_valid = 1'b1; tx_slot_avail = 1'b1;
    for (int m = 0; m < 8; m++) begin
      g = order_c[m];
      rep_data = mk(10 + rm, rc); rep_last = (rc == 1);
      req_data = mk(20 + qm, qc); req_last = (qc == 1);
      @(negedge clk);
      checks += 2;
      if (tx_ipg_valid !== hs_prev) begin errors++; $display("FAIL weighting bubble tx_valid[%0d]: got %b want %b", m, tx_ipg_valid, hs_prev); end
      if (hs_prev) begin
        exp_d = exp_q.pop_front(); checks++;
        if (tx_ipg_data !== exp_d) begin errors++; $display("FAIL weighting tx_data: got %h want %h", tx_ipg_data, exp_d); end
      end
      if (grant_src !== 2'b00) begin errors++; $display("FAIL weighting bubble grant[%0d]: got %b want 00", m, grant_src); end
      hs_prev = 1'b0;
      tick();
      for (int c = 0; c < 2; c++) begin
        rep_data = mk(10 + rm, rc); rep_last = (rc == 1);
        req_data = mk(20 + qm, qc); req_last = (qc == 1);
        @(negedge clk);
        checks += 4;
        if (tx_ipg_valid !== hs_prev) begin errors++; $display("FAIL weighting tx_valid[%0d.%0d]: got %b want %b", m, c, tx_ipg_valid, hs_prev); end
        if (hs_prev) begin
          exp_d = exp_q.pop_front(); checks++;
          if (tx_ipg_data !== exp_d) begin errors++; $display("FAIL weighting tx_data: got %h want %h", tx_ipg_data, exp_d); end
        end
        if (grant_src !== g) begin errors++; $display("FAIL weighting order[%0d]: got %b want %b", m, grant_src, g); end
        if (rep_ready !== g[0]) begin errors++; $display("FAIL weighting rep_ready[%0d]: got %b want %b", m, rep_ready, g[0]); end
        if (req_ready !== g[1]) begin errors++; $display("FAIL weighting req_ready[%0d]: got %b want %b", m, req_ready, g[1]); end
        exp_q.push_back(g[0] ? mk(10 + rm, rc) : mk(20 + qm, qc));
        hs_prev = 1'b1;
        tick();
        if (g[0]) begin
          rc++;
          if (rc == 2) begin rc = 0; rm++; end
        end else begin
          qc++;
          if (qc == 2) begin qc = 0; qm++; end
        end
      end
    end
    rep_valid = 1'b0; req_valid = 1'b0; rep_last = 1'b0; req_last = 1'b0;
    @(negedge clk);
    exp_d = exp_q.pop_front();
    checks += 2;
    if (tx_ipg_valid !== 1'b1) begin errors++; $display("FAIL weighting last tx_valid: got %b want 1", tx_ipg_valid); end
    if (tx_ipg_data !== exp_d) begin errors++; $display("FAIL weighting last tx_data: got %h want %h", tx_ipg_data, exp_d); end
    tick();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL weighting scoreboard: got %0d left want 0", exp_q.size()); end
    tick();
  endtask

  task automatic test_timeout();
    logic hs_prev;
    logic [63:0] exp_d;
    rep_valid = 1'b1; rep_data = mk(30, 0); rep_last = 1'b0; tx_slot_avail = 1'b1;
    @(negedge clk);
    tick();
    hs_prev = 1'b0;
    for (int c = 0; c < 2; c++) begin
      rep_data = mk(30, c);
      @(negedge clk);
      checks += 2;
      if (tx_ipg_valid !== hs_prev) begin errors++; $display("FAIL timeout tx_valid[%0d]: got %b want %b", c, tx_ipg_valid, hs_prev); end
      if (hs_prev) begin
        exp_d = exp_q.pop_front(); checks++;
        if (tx_ipg_data !== exp_d) begin errors++; $display("FAIL timeout tx_data: got %h want %h", tx_ipg_data, exp_d); end
      end
      if (grant_src !== 2'b01) begin errors++; $display("FAIL timeout grant[%0d]: got %b want 01", c, grant_src); end
      exp_q.push_back(mk(30, c)); hs_prev = 1'b1;
      tick();
    end
    rep_valid = 1'b0;
    req_valid = 1'b1; req_data = mk(31, 0); req_last = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      checks += 4;
      if (tx_ipg_valid !== hs_prev) begin errors++; $display("FAIL timeout stall tx_valid[%0d]: got %b want %b", n, tx_ipg_valid, hs_prev); end
      if (hs_prev) begin
        exp_d = exp_q.pop_front(); checks++;
        if (tx_ipg_data !== exp_d) begin errors++; $display("FAIL timeout tx_data: got %h want %h", tx_ipg_data, exp_d); end
      end
      if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout early err[%0d]: got %b want 0", n, err_timeout); end
      if (grant_src !== 2'b01) begin errors++; $display("FAIL timeout held grant[%0d]: got %b want 01", n, grant_src); end
      if (req_ready !== 1'b0) begin errors++; $display("FAIL timeout req_ready[%0d]: got %b want 0", n, req_ready); end
      hs_prev = 1'b0;
      tick();
    end
    @(negedge clk);
    checks += 3;
    if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout pulse: got %b want 1", err_timeout); end
    if (grant_src !== 2'b00) begin errors++; $display("FAIL timeout idle grant: got %b want 00", grant_src); end
    if (tx_ipg_valid !== 1'b0) begin errors++; $display("FAIL timeout abort tx_valid: got %b want 0", tx_ipg_valid); end
    tick();
    @(negedge clk);
    checks += 3;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout pulse width: got %b want 0", err_timeout); end
    if (grant_src !== 2'b10) begin errors++; $display("FAIL timeout next grant: got %b want 10", grant_src); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL timeout next req_ready: got %b want 1", req_ready); end
    exp_q.push_back(mk(31, 0));
    tick();
    req_valid = 1'b0; req_last = 1'b0;
    @(negedge clk);
    exp_d = exp_q.pop_front();
    checks += 3;
    if (tx_ipg_valid !== 1'b1) begin errors++; $display("FAIL timeout req tx_valid: got %b want 1", tx_ipg_valid); end
    if (tx_ipg_data !== exp_d) begin errors++; $display("FAIL timeout req tx_data: got %h want %h", tx_ipg_data, exp_d); end
    if (grant_src !== 2'b00) begin errors++; $display("FAIL timeout single-chunk idle grant: got %b want 00", grant_src); end
    tick();
  endtask

  task automatic test_mid_reset();
    logic hs_prev;
    logic [63:0] exp_d;
    rep_valid = 1'b1; rep_data = mk(40, 0); rep_last = 1'b0; tx_slot_avail = 1'b1;
    @(negedge clk);
    tick();
    hs_prev = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rep_data = mk(40, c);
      @(negedge clk);
      checks++;
      if (tx_ipg_valid !== hs_prev) begin errors++; $display("FAIL mid_reset tx_valid[%0d]: got %b want %b", c, tx_ipg_valid, hs_prev); end
      if (hs_prev) begin
        exp_d = exp_q.pop_front(); checks++;
        if (tx_ipg_data !== exp_d) begin errors++; $display("FAIL mid_reset tx_data: got %h want %h", tx_ipg_data, exp_d); end
      end
      exp_q.push_back(mk(40, c)); hs_prev = 1'b1;
      tick();
    end
    rep_data = mk(40, 3);
    reset = 1'b0;
    @(negedge clk);
    exp_d = exp_q.pop_front();
    checks += 2;
    if (tx_ipg_valid !== 1'b1) begin errors++; $display("FAIL mid_reset chunk3 tx_valid: got %b want 1", tx_ipg_valid); end
    if (tx_ipg_data !== exp_d) begin errors++; $display("FAIL mid_reset chunk3 tx_data: got %h want %h", tx_ipg_data, exp_d); end
    tick();
    reset = 1'b1; rep_valid = 1'b0;
    @(negedge clk);
    checks += 5;
    if (tx_ipg_valid !== 1'b0) begin errors++; $display("FAIL mid_reset post tx_valid: got %b want 0", tx_ipg_valid); end
    if (tx_ipg_data !== 64'd0) begin errors++; $display("FAIL mid_reset post tx_data: got %h want 0", tx_ipg_data); end
    if (grant_src !== 2'b00) begin errors++; $display("FAIL mid_reset post grant: got %b want 00", grant_src); end
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL mid_reset post err_timeout: got %b want 0", err_timeout); end
    if (rep_ready !== 1'b0) begin errors++; $display("FAIL mid_reset post rep_ready: got %b want 0", rep_ready); end
    for (int n = 0; n < 4; n++) begin
      tick();
      @(negedge clk);
      checks++;
      if (tx_ipg_valid !== 1'b0) begin errors++; $display("FAIL mid_reset abandoned tx_valid[%0d]: got %b want 0", n, tx_ipg_valid); end
    end
    tick();
    rep_valid = 1'b1; rep_data = mk(41, 0); rep_last = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks += 2;
    if (grant_src !== 2'b01) begin errors++; $display("FAIL mid_reset regrant: got %b want 01", grant_src); end
    if (rep_ready !== 1'b1) begin errors++; $display("FAIL mid_reset regrant rep_ready: got %b want 1", rep_ready); end
    exp_q.push_back(mk(41, 0));
    tick();
    rep_valid = 1'b0; rep_last = 1'b0;
    @(negedge clk);
    exp_d = exp_q.pop_front();
    checks += 2;
    if (tx_ipg_valid !== 1'b1) begin errors++; $display("FAIL mid_reset new msg tx_valid: got %b want 1", tx_ipg_valid); end
    if (tx_ipg_data !== exp_d) begin errors++; $display("FAIL mid_reset new msg tx_data: got %h want %h", tx_ipg_data, exp_d); end
    tick();
  endtask

`ifdef IPG_BT_CHECK_EN
  task automatic test_bt_check();
    logic fwd_prev;
    logic bt_prev;
    logic [63:0] exp_d;
    logic [63:0] chunk;
    rep_valid = 1'b1; rep_data = mk(50, 0); rep_last = 1'b0; tx_slot_avail = 1'b1;
    @(negedge clk);
    tick();
    fwd_prev = 1'b0; bt_prev = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chunk = mk(50, c);
      if (c == 1) begin chunk[7:0] = 8'h33; end
      rep_data = chunk; rep_last = (c == 2); rep_valid = (c < 3);
      @(negedge clk);
      checks += 2;
      if (tx_ipg_valid !== fwd_prev) begin errors++; $display("FAIL bt_check tx_valid[%0d]: got %b want %b", c, tx_ipg_valid, fwd_prev); end
      if (fwd_prev) begin
        exp_d = exp_q.pop_front(); checks++;
        if (tx_ipg_data !== exp_d) begin errors++; $display("FAIL bt_check tx_data: got %h want %h", tx_ipg_data, exp_d); end
      end
      if (err_bt !== bt_prev) begin errors++; $display("FAIL bt_check err_bt[%0d]: got %b want %b", c, err_bt, bt_prev); end
      fwd_prev = (c < 3) && (c != 1);
      bt_prev = (c == 1);
      if (fwd_prev) begin exp_q.push_back(chunk); end
      tick();
    end
    rep_valid = 1'b0; rep_last = 1'b0;
  endtask
`endif

  initial begin
    idle_inputs();
    reset = 1'b0;
    tx_slot_avail = 1'b0;
    test_reset();
    test_reply_only();
    test_back_pressure();
    test_weighting();
    test_timeout();
    test_mid_reset();
`ifdef IPG_BT_CHECK_EN
    test_bt_check();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ipg_tx_arbiter.md
Name: ipg_tx_arbiter

Overview:
- Shares the IPG transmit slot between two message sources.
  - Reply source: the memq output of the IPG processor, carrying memory replies.
  - Request source: the local request queue, carrying outgoing c_read/c_write messages.
- Forwards 64-bit control-block chunks into PHY idle slots.
- Grants are message-atomic, with weighted priority toward replies and a mid-message timeout.

Parameters:
- REPLY_WEIGHT, 3: consecutive reply messages allowed while a request is pending before the request source is served.
- TIMEOUT, 16: idle-slot cycles a granted source may stall mid-message before the message is aborted.
- STREAK_W, 4: width of the reply streak counter; must satisfy REPLY_WEIGHT < 2^STREAK_W.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- rep_data  in  64  reply chunk; bits [7:0] are the block type.
- rep_valid  in  1  reply chunk valid.
- rep_last  in  1  final chunk of the reply message.
- rep_ready  out  1  reply chunk accepted this cycle.
- req_data  in  64  request chunk.
- req_valid  in  1  request chunk valid.
- req_last  in  1  final chunk of the request message.
- req_ready  out  1  request chunk accepted this cycle.
- tx_slot_avail  in  1  PHY can carry a control block this cycle.
- tx_ipg_data  out  64  registered chunk to the PHY.
- tx_ipg_valid  out  1  tx_ipg_data is valid.
- grant_src  out  2  one-hot: bit0 = reply granted, bit1 = request granted.
- err_timeout  out  1  one-cycle pulse when a message is aborted.

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE; streak=0; gap counter=0.
  - All outputs go to 0.
  - A message in flight is abandoned: no further chunks are emitted.
- States are IDLE, BUSY_REP and BUSY_REQ.
- IDLE:
  - rep_ready = req_ready = 0.
  - Only rep_valid asserted -> BUSY_REP next cycle.
  - Only req_valid asserted -> BUSY_REQ next cycle.
  - Both asserted -> BUSY_REQ if streak==REPLY_WEIGHT, else BUSY_REP.
  - Neither asserted -> remain in IDLE.
  - There is always a one-cycle arbitration bubble between messages.
- BUSY_x:
  - x_ready = tx_slot_avail, combinational.
  - The other source's ready is held at 0.
  - grant_src reflects the current state.
- Handshake (x_valid && x_ready):
  - The next cycle has tx_ipg_valid=1 and tx_ipg_data = the accepted chunk.
  - tx_ipg_valid=0 in every other cycle.
  - Latency is exactly 1 cycle.
- On a handshake with x_last=1:
  - The next state is IDLE.
  - Reply message completed -> streak = streak+1, saturating at REPLY_WEIGHT.
  - Request message completed -> streak = 0.
- A single-chunk message (last=1 on its first chunk) is legal.
- Timeout:
  - In BUSY_x, the gap counter increments on each cycle with tx_slot_avail=1 && x_valid=0.
  - It clears on a handshake.
  - Cycles with tx_slot_avail=0 neither count nor clear it.
  - When gap counter == TIMEOUT-1 and it would increment: next state is IDLE, err_timeout pulses for 1 cycle, the counter clears, and streak is unchanged.
- A handshake and a timeout can never coincide, because the timeout requires x_valid=0.
- While a source holds the grant, the other source's valid is ignored and its data is not sampled.

Optional Feature:
- Macro: IPG_BT_CHECK_EN.
- Defined:
  - A granted chunk whose [7:0] != 8'h1e is still accepted (ready asserted).
  - It is discarded: tx_ipg_valid stays 0 the next cycle.
  - Extra output err_bt (1 bit) pulses for 1 cycle.
  - Grant, last and streak handling are unchanged.
- Undefined: no err_bt port; every chunk is forwarded unmodified.

Test Plan:
- Reply only:
  - Stimulus: reply message of 10 chunks, tx_slot_avail=1 throughout.
  - Response: grant_src=01 one cycle after rep_valid; 10 consecutive tx_ipg_valid cycles with data matching in order; return to IDLE.
- Weighting:
  - Stimulus: both sources continuously valid, each message 2 chunks, REPLY_WEIGHT=3.
  - Response: served message order REP,REP,REP,REQ,REP,REP,REP,REQ; streak is 0 after each REQ.
- Slot back-pressure:
  - Stimulus: tx_slot_avail toggles 1,0,1,0 during a 4-chunk request.
  - Response: req_ready mirrors tx_slot_avail; 4 outputs spaced 2 cycles apart; no timeout.
- Timeout:
  - Stimulus: reply grants, sends 2 chunks, then rep_valid=0 with tx_slot_avail=1, TIMEOUT=16.
  - Response: err_timeout pulses exactly 16 cycles after the last handshake; state returns to IDLE; a pending request is granted next.
- Mid-message reset:
  - Stimulus: reset=0 for 1 cycle after the 3rd chunk of a 6-chunk message.
  - Response: all outputs are 0 the following cycle; no chunks 4–6 are emitted until a new arbitration occurs.
- With IPG_BT_CHECK_EN:
  - Stimulus: chunk with [7:0]=8'h33 inside a reply.
  - Response: chunk consumed, err_bt=1 for 1 cycle, tx_ipg_valid=0 for that slot; neighbouring chunks are forwarded.
